// File: rtl/alu_seq.sv
// alu_seq_pkg / alu_seq
//
// Multi-byte sequential ALU engine. On an accepted start it walks `len` bytes
// little-endian: it reads one byte of A, one byte of B, runs them through an
// external combinational ALU with a chained carry, and writes the result byte
// back to memory. Flags are loaded once, when the whole operation completes.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start, op, len, carry_in    request pulse, operation code, byte count, external carry/borrow
//   a_base, b_base, d_base      operand A, operand B and destination base addresses
//   busy, done, err             engine active, completion pulse, illegal-op pulse
//   flag_c, flag_z              carry/borrow and zero flags of the last completed operation
//   rd_addr, rd_data            memory read port (data valid the cycle after the address)
//   wr_en, wr_addr, wr_data     memory write port
//   alu_cs, alu_a, alu_b, alu_cin          controls to the external ALU
//   alu_s, alu_zero, alu_cout              results from the external ALU

package alu_seq_pkg;

    // ALU control codes shared with the external ALU.
    localparam int AC_W = 2;
    localparam logic [AC_W-1:0] AC_AD = 2'd0;  // a + b + cin
    localparam logic [AC_W-1:0] AC_SB = 2'd1;  // a + ~b + cin, cout reports borrow
    localparam logic [AC_W-1:0] AC_AN = 2'd2;  // a & b
    localparam logic [AC_W-1:0] AC_OR = 2'd3;  // a | b

    // Operation codes on the op input.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;

endpackage

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            start,
    input  logic [2:0]      op,
    input  logic [3:0]      len,
    input  logic [AW-1:0]   a_base,
    input  logic [AW-1:0]   b_base,
    input  logic [AW-1:0]   d_base,
    input  logic            carry_in,

    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            flag_c,
    output logic            flag_z,

    output logic [AW-1:0]   rd_addr,
    input  logic [N-1:0]    rd_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [N-1:0]    wr_data,

    output logic [AC_W-1:0] alu_cs,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic            alu_cin,
    input  logic [N-1:0]    alu_s,
    input  logic            alu_zero,
    input  logic            alu_cout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_DONE
    } state_e;

    state_e          state_q;
    logic [3:0]      i_q;
    logic [2:0]      op_q;
    logic [3:0]      len_q;
    logic [AW-1:0]   a_base_q;
    logic [AW-1:0]   b_base_q;
    logic [AW-1:0]   d_base_q;
    logic [N-1:0]    a_byte_q;
    logic            carry_q;      // carry fed into the next byte (ALU carry sense)
    logic            cout_last_q;  // flag_c candidate from the most recent byte
    logic            zacc_q;       // AND of alu_zero over all bytes so far
    logic            done_q;
    logic            err_q;
    logic            flag_c_q;
    logic            flag_z_q;

    logic [AC_W-1:0] alu_cs_d;
    logic            is_arith_d;
    logic            is_sub_d;
    logic            carry_d;
    logic            cout_last_d;
    logic            carry_init_d;

    // Decode of the latched operation.
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_cs_d   = AC_OR;
        is_arith_d = 1'b0;
        is_sub_d   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                alu_cs_d   = AC_AD;
                is_arith_d = 1'b1;
            end
            OP_SUB, OP_SBB: begin
                alu_cs_d   = AC_SB;
                is_arith_d = 1'b1;
                is_sub_d   = 1'b1;
            end
            OP_AND:  alu_cs_d = AC_AN;
            default: alu_cs_d = AC_OR;
        endcase
    end

    // alu_cout is a borrow for AC_SB, while alu_cin always uses carry sense,
    // so the chain inverts it for subtraction. The flag keeps the raw borrow.
    assign carry_d     = is_arith_d & (is_sub_d ? ~alu_cout : alu_cout);
    assign cout_last_d = is_arith_d & alu_cout;

    // Initial chained carry, taken from the op/carry_in present at acceptance.
    always_comb begin
        carry_init_d = 1'b0;
        case (op)
            OP_ADC:  carry_init_d = carry_in;
            OP_SUB:  carry_init_d = 1'b1;
            OP_SBB:  carry_init_d = ~carry_in;
            default: carry_init_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            op_q        <= OP_ADD;
            len_q       <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            d_base_q    <= '0;
            a_byte_q    <= '0;
            carry_q     <= 1'b0;
            cout_last_q <= 1'b0;
            zacc_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op > OP_OR) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q        <= op;
                            len_q       <= len;
                            a_base_q    <= a_base;
                            b_base_q    <= b_base;
                            d_base_q    <= d_base;
                            i_q         <= '0;
                            carry_q     <= carry_init_d;
                            cout_last_q <= 1'b0;
                            zacc_q      <= 1'b1;
                            state_q     <= (len == 4'd0) ? ST_DONE : ST_RD_A;
                        end
                    end
                end
                ST_RD_A: state_q <= ST_RD_B;
                ST_RD_B: begin
                    // rd_data now holds the A byte addressed in RD_A.
                    a_byte_q <= rd_data;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    carry_q     <= carry_d;
                    cout_last_q <= cout_last_d;
                    zacc_q      <= zacc_q & alu_zero;
                    if (i_q == len_q - 4'd1) begin
                        state_q <= ST_DONE;
                    end else begin
                        i_q     <= i_q + 4'd1;
                        state_q <= ST_RD_A;
                    end
                end
                ST_DONE: begin
                    done_q   <= 1'b1;
                    flag_c_q <= cout_last_q;
                    flag_z_q <= zacc_q;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory and ALU drive, decoded from the state register. Addresses wrap
    // naturally because the sums are AW bits wide.
    always_comb begin
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        alu_cs  = AC_AD;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        case (state_q)
            ST_RD_A: rd_addr = a_base_q + AW'(i_q);
            ST_RD_B: rd_addr = b_base_q + AW'(i_q);
            ST_EXEC: begin
                alu_cs  = alu_cs_d;
                alu_a   = a_byte_q;
                alu_b   = rd_data;
                alu_cin = carry_q;
                wr_en   = 1'b1;
                wr_addr = d_base_q + AW'(i_q);
                wr_data = alu_s;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign flag_c = flag_c_q;
    assign flag_z = flag_z_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter N, default 8, datapath/byte width in bits.
REQ-002 SHALL have parameter AW, default 8, memory address width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports start input 1 (request pulse), op input 3 (operation), len input 4 (byte count), a_base, b_base, d_base input AW each (operand A, operand B, destination base addresses), carry_in input 1 (external carry/borrow for ADC/SBB).
REQ-006 SHALL have ports busy output 1, done output 1 (one-cycle pulse), err output 1 (one-cycle pulse), flag_c output 1, flag_z output 1.
REQ-007 SHALL have memory ports rd_addr output AW, rd_data input N (valid the cycle after rd_addr), wr_en output 1, wr_addr output AW, wr_data output N.
REQ-008 SHALL have ALU ports alu_cs output (shared ALU control width, AC_* codes from the shared ALU interface include), alu_a output N, alu_b output N, alu_cin output 1, alu_s input N, alu_zero input 1, alu_cout input 1; the ALU is combinational, result valid the same cycle.

Function
REQ-009 SHALL implement states IDLE, RD_A, RD_B, EXEC, DONE; byte index i (4 bits) counts 0..len-1, little-endian (i=0 least significant).
REQ-010 SHALL accept start only in IDLE; start while busy is ignored; busy=1 in every state except IDLE.
REQ-011 SHALL decode op: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 OR; op 6/7 illegal -> err pulse next cycle, stay IDLE, no memory or flag change.
REQ-012 SHALL on accepted legal start with len=0 go to DONE directly: no reads/writes, flag_c=0, flag_z=1.
REQ-013 SHALL in RD_A drive rd_addr=a_base+i; in RD_B drive rd_addr=b_base+i and capture rd_data as A byte.
REQ-014 SHALL in EXEC drive alu_a=A byte, alu_b=rd_data, alu_cin=chained carry, assert wr_en for exactly this cycle with wr_addr=d_base+i, wr_data=alu_s.
REQ-015 SHALL compute all addresses modulo 2^AW (wrap-around, no error).
REQ-016 SHALL use alu_cs=AC_AD for ADD/ADC, AC_SB for SUB/SBB, AC_AN for AND, AC_OR for OR.
REQ-017 SHALL set initial chained carry: ADD 0, ADC carry_in, SUB 1, SBB ~carry_in, AND/OR 0 (carry_in sampled at start acceptance).
REQ-018 SHALL update chained carry after each EXEC: ADD/ADC <- alu_cout; SUB/SBB <- ~alu_cout (alu_cout is borrow for AC_SB); AND/OR <- 0.
REQ-019 SHALL accumulate zero as AND of alu_zero over all bytes.
REQ-020 SHALL from EXEC go to DONE if i==len-1, else increment i and go to RD_A.
REQ-021 SHALL in DONE pulse done=1 for one cycle, load flag_c = last alu_cout (borrow for SUB/SBB, 0 for AND/OR) and flag_z = accumulated zero, then return to IDLE.
REQ-022 SHALL hold flag_c/flag_z stable from DONE until the next DONE; latency start-accept to done = 3*len+1 cycles.
REQ-023 SHALL drive wr_en=0 outside EXEC; rd_addr, alu_* are don't-care but stable-defined (0) in IDLE/DONE.

Reset
REQ-024 SHALL on rst_n=0 at a rising edge enter IDLE, i=0, busy=0, done=0, err=0, wr_en=0, flag_c=0, flag_z=0.
REQ-025 SHALL abort any operation in progress on reset with no further write after the reset edge; partially written destination bytes are not restored.

Verification
REQ-026 ADD len=2, A=0x12FF, B=0x0001 -> mem D=0x1300, flag_c=0, flag_z=0, done 7 cycles after acceptance.
REQ-027 ADD len=2, A=0xFFFF, B=0x0001 -> D=0x0000, flag_c=1, flag_z=1.
REQ-028 SUB len=2, A=0x0100, B=0x0001 -> D=0x00FF, flag_c=0; A=0x0000, B=0x0001 -> D=0xFFFF, flag_c=1.
REQ-029 op=6 -> err pulse, no wr_en, flags unchanged; len=0 ADD -> done after 1 cycle, flag_z=1, no memory access.
REQ-030 d_base=0xFF, len=2 -> writes to 0xFF then 0x00; start during busy ignored; rst_n=0 during EXEC of byte 1 -> IDLE next cycle, busy=0, no further wr_en.
